axis_fifo_reader: RTL and testbench
===================================

# axis_fifo_reader

Read-side consumer for the AXI4-Stream FIFO output. Pops one word at a time from an AXI-Stream master (the FIFO `m_axis_*` port) into a CPU-readable holding register, advanced by a bus read strobe. Tracks frame boundaries, completed-frame length, intra-frame idle timeout and read underflow. Supports a flush that discards the remainder of the current frame. Sits between the I2C data FIFO and the register file.

## Interface
- `DATA_WIDTH`, 8, data word width
- `USER_WIDTH`, 1, tuser width
- `LEN_WIDTH`, 16, frame length counter width
- `TO_WIDTH`, 16, idle timeout counter width

- `clk`  in  1  clock; all logic is on the rising edge
- `rst_n`  in  1  reset; synchronous and active-low
- `s_axis_tdata`  in  DATA_WIDTH  stream data
- `s_axis_tvalid`  in  1  stream valid
- `s_axis_tready`  out  1  stream ready (combinational)
- `s_axis_tlast`  in  1  end of frame
- `s_axis_tuser`  in  USER_WIDTH  sideband, captured with the word
- `rd_en`  in  1  one-cycle bus read strobe of the data register
- `flush`  in  1  one-cycle request to discard the held word and the rest of the frame
- `timeout_cfg`  in  TO_WIDTH  idle-cycle limit; 0 disables the timeout
- `rd_data`  out  DATA_WIDTH  held word
- `rd_valid`  out  1  holding register full
- `rd_last`  out  1  tlast of the held word
- `rd_user`  out  USER_WIDTH  tuser of the held word
- `frame_len`  out  LEN_WIDTH  word count of the last completed, non-dropped frame
- `frame_done`  out  1  one-cycle pulse when a tlast word is captured
- `timeout`  out  1  one-cycle pulse when the intra-frame idle limit is hit
- `underflow`  out  1  one-cycle pulse when `rd_en` arrives with `rd_valid` = 0

## Operation
- **States:** EMPTY, FULL, DROP. `rd_valid` = (state == FULL).
- **`s_axis_tready`** = `rst_n` & ((EMPTY) | (FULL & `rd_en` & !`flush`) | (DROP)).
- **Capture** (handshake in EMPTY or FULL):
  - Load `rd_data`, `rd_last`, `rd_user`; next state FULL.
  - Read-and-refill in the same cycle keeps FULL with the new word.
- **Read without refill:** `rd_en` in FULL with no handshake -> EMPTY. Data outputs hold their last values.
- **Underflow:** `rd_en` with state != FULL and `flush` = 0 -> `underflow` pulse. No other effect.
- **Frame length** (`cur_len`, internal):
  - Increments on each captured non-last word, saturating at all-ones.
  - On a captured tlast word: `frame_len` <= sat(`cur_len` + 1), `cur_len` <= 0, `frame_done` pulse.
- **`in_frame`:** set on capture of a non-last word; cleared on capture of a tlast word, on timeout, and on flush.
- **Timeout:**
  - `idle_cnt` increments each cycle while `in_frame` & !`s_axis_tvalid` & `timeout_cfg` != 0.
  - It clears on any handshake.
  - When `idle_cnt` + 1 == `timeout_cfg`: `timeout` pulse, `in_frame` <= 0, `cur_len` <= 0, `idle_cnt` <= 0. `frame_len` is not updated.
- **Flush:**
  - `rd_valid` <= 0 and `cur_len` <= 0.
  - Next state is DROP if `in_frame`, else EMPTY.
  - `flush` overrides `rd_en`: no underflow, no capture that cycle.
- **DROP:**
  - Accepts and discards every word.
  - On a tlast handshake -> EMPTY.
  - Does not count words, pulse `frame_done`, or run the timeout.
  - `flush` in DROP stays in DROP.

## Timing
- **Reset:** all outputs are 0 while `rst_n` = 0 (`s_axis_tready` included). State returns to EMPTY and all counters and `in_frame` clear on the first edge with `rst_n` low, regardless of state (mid-frame, DROP).
- **Capture-to-`rd_valid` latency:** 1 cycle; the word is visible the cycle after the handshake.
- **`rd_en` to refill:** same-cycle handshake allowed. Sustained throughput is 1 word/cycle with `rd_en` held high and the source valid.
- **Pulses:** `frame_done`, `timeout` and `underflow` are registered, exactly 1 cycle wide, and asserted the cycle after the causing event.
- **Timeout/handshake collision:** a handshake in the same cycle as the timeout terminal count wins; no timeout fires.

## Structure
- **Shared package `axis_reader_pkg`:** state encoding localparams `ST_EMPTY`=2'd0, `ST_FULL`=2'd1, `ST_DROP`=2'd2.
- **Sub-module `axis_idle_timer`** (TO_WIDTH counter, enable, clear, cfg, terminal pulse) is natural; reused by the TX side.
- The rest is flat.

## Test plan
- **Basic frame:** 3-word frame 0x11, 0x22, 0x33(last), with `rd_en` one cycle after each `rd_valid` -> reads 0x11, 0x22, 0x33; `rd_last` only on 0x33; `frame_len` = 3; a single `frame_done` pulse.
- **Back-to-back streaming:** `rd_en` held high and tvalid high for 8 words -> `s_axis_tready` = 1 every cycle after the first capture; 8 words delivered in 9 cycles.
- **Underflow:** `rd_en` at reset exit -> one `underflow` pulse; `rd_data` = 0; `rd_valid` = 0.
- **Timeout:** `timeout_cfg` = 4; one non-last word, then tvalid low -> `timeout` pulse exactly 4 idle cycles later; next tlast frame of 2 words gives `frame_len` = 2.
- **Flush mid-frame:** flush after word 2 of 5, same cycle as `rd_en` -> no underflow; words 3–5 accepted and discarded with tready = 1; no `frame_done`; next frame captured normally.
- **Reset mid-frame:** `rst_n` low 1 cycle while FULL mid-frame -> all outputs 0; next frame `frame_len` counts from 0.

Source files
------------

// File: rtl/axis_reader_pkg.sv
// Shared definitions for the AXI-Stream FIFO reader and its helpers.
// State encoding is fixed so that register-file and debug views stay stable.
package axis_reader_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_EMPTY = 2'd0;
    localparam logic [ST_W-1:0] ST_FULL  = 2'd1;
    localparam logic [ST_W-1:0] ST_DROP  = 2'd2;

endpackage

// File: rtl/axis_idle_timer.sv
// Idle-cycle counter with a programmable limit; a cfg of zero disables it.
// expire_c is combinational so the owner can register it alongside its own side effects.
module axis_idle_timer #(
    parameter int unsigned TO_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic [TO_WIDTH-1:0] cfg,
    output logic                expire_c
);

    logic [TO_WIDTH-1:0] cnt;
    logic [TO_WIDTH-1:0] cnt_inc;
    logic                run;

    assign cnt_inc  = cnt + TO_WIDTH'(1);
    assign run      = en && (cfg != '0);
    // A clear in the terminal cycle suppresses the expiry.
    assign expire_c = run && !clr && (cnt_inc == cfg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || expire_c) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/axis_fifo_reader.sv
// Pops AXI-Stream words into a CPU-readable holding register, advanced by rd_en.
// Tracks frame length, intra-frame idle timeout, read underflow and frame flush.
module axis_fifo_reader
    import axis_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned TO_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    input  logic                  rd_en,
    input  logic                  flush,
    input  logic [TO_WIDTH-1:0]   timeout_cfg,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic [USER_WIDTH-1:0] rd_user,
    output logic [LEN_WIDTH-1:0]  frame_len,
    output logic                  frame_done,
    output logic                  timeout,
    output logic                  underflow
);

    logic [ST_W-1:0]       state;
    logic [ST_W-1:0]       state_nxt;
    logic                  in_frame;
    logic                  in_frame_nxt;
    logic [LEN_WIDTH-1:0]  cur_len;
    logic [LEN_WIDTH-1:0]  cur_len_nxt;
    logic [LEN_WIDTH-1:0]  len_inc;
    logic [LEN_WIDTH-1:0]  frame_len_nxt;
    logic [DATA_WIDTH-1:0] rd_data_nxt;
    logic                  rd_last_nxt;
    logic [USER_WIDTH-1:0] rd_user_nxt;
    logic                  frame_done_nxt;
    logic                  timeout_nxt;
    logic                  underflow_nxt;
    logic                  hs;
    logic                  capture;
    logic                  timer_en;
    logic                  tmo_c;

    assign s_axis_tready = rst_n && ((state == ST_EMPTY)
                                  || ((state == ST_FULL) && rd_en && !flush)
                                  || (state == ST_DROP));
    assign hs       = s_axis_tvalid && s_axis_tready;
    // A flush in EMPTY still handshakes, but the word is discarded.
    assign capture  = hs && !flush && (state != ST_DROP);
    assign len_inc  = (cur_len == '1) ? cur_len : cur_len + LEN_WIDTH'(1);
    assign rd_valid = (state == ST_FULL);
    assign timer_en = in_frame && !s_axis_tvalid && (state != ST_DROP);

    axis_idle_timer #(
        .TO_WIDTH (TO_WIDTH)
    ) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (timer_en),
        .clr      (hs),
        .cfg      (timeout_cfg),
        .expire_c (tmo_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt      = state;
        in_frame_nxt   = in_frame;
        cur_len_nxt    = cur_len;
        frame_len_nxt  = frame_len;
        rd_data_nxt    = rd_data;
        rd_last_nxt    = rd_last;
        rd_user_nxt    = rd_user;
        frame_done_nxt = 1'b0;
        timeout_nxt    = tmo_c;
        underflow_nxt  = rd_en && (state != ST_FULL) && !flush;

        case (state)
            ST_EMPTY, ST_FULL: begin
                if (flush) begin
                    state_nxt = in_frame ? ST_DROP : ST_EMPTY;
                end else if (capture) begin
                    state_nxt = ST_FULL;
                end else if ((state == ST_FULL) && rd_en) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_DROP: begin
                if (!flush && hs && s_axis_tlast) begin
                    state_nxt = ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase

        if (capture) begin
            rd_data_nxt = s_axis_tdata;
            rd_last_nxt = s_axis_tlast;
            rd_user_nxt = s_axis_tuser;
            if (s_axis_tlast) begin
                frame_len_nxt  = len_inc;
                cur_len_nxt    = '0;
                in_frame_nxt   = 1'b0;
                frame_done_nxt = 1'b1;
            end else begin
                cur_len_nxt  = len_inc;
                in_frame_nxt = 1'b1;
            end
        end

        if (tmo_c || flush) begin
            in_frame_nxt = 1'b0;
            cur_len_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            in_frame   <= 1'b0;
            cur_len    <= '0;
            frame_len  <= '0;
            rd_data    <= '0;
            rd_last    <= 1'b0;
            rd_user    <= '0;
            frame_done <= 1'b0;
            timeout    <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_frame   <= in_frame_nxt;
            cur_len    <= cur_len_nxt;
            frame_len  <= frame_len_nxt;
            rd_data    <= rd_data_nxt;
            rd_last    <= rd_last_nxt;
            rd_user    <= rd_user_nxt;
            frame_done <= frame_done_nxt;
            timeout    <= timeout_nxt;
            underflow  <= underflow_nxt;
        end
    end

endmodule

// File: tb/tb_axis_fifo_reader.sv
// Self-checking bench for axis_fifo_reader: directed vectors, corner sequences
// and randomized traffic compared against a queue-based behavioural model.
module tb_axis_fifo_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned UW = 1;
    localparam int unsigned LW = 16;
    localparam int unsigned TW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [UW-1:0] s_axis_tuser;
    logic          rd_en;
    logic          flush;
    logic [TW-1:0] timeout_cfg;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_last;
    logic [UW-1:0] rd_user;
    logic [LW-1:0] frame_len;
    logic          frame_done;
    logic          timeout;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axis_fifo_reader #(
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW),
        .LEN_WIDTH  (LW),
        .TO_WIDTH   (TW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .rd_en         (rd_en),
        .flush         (flush),
        .timeout_cfg   (timeout_cfg),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_last       (rd_last),
        .rd_user       (rd_user),
        .frame_len     (frame_len),
        .frame_done    (frame_done),
        .timeout       (timeout),
        .underflow     (underflow)
    );

    // Behavioural model: a 0/1-entry holding queue plus frame bookkeeping.
    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [UW-1:0] user;
    } word_t;

    word_t         m_held[$];
    word_t         m_out;
    bit            m_drop;
    bit            m_in_frame;
    int            m_len;
    int            m_frame_len;
    logic [TW-1:0] m_idle;
    bit            m_fd;
    bit            m_to;
    bit            m_uf;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
        logic          l;
        logic          re;
        logic          ev;
        logic [DW-1:0] ed;
        logic          el;
        logic          efd;
        logic [LW-1:0] elen;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int x);
        return (x >= 65535) ? 65535 : x + 1;
    endfunction

    task automatic model_step(input logic v, input logic [DW-1:0] d, input logic l,
                              input logic [UW-1:0] u, input logic re, input logic fl,
                              input logic rst, output bit ready);
        bit    hs;
        bit    idle_run;
        word_t w;
        if (!rst) begin
            m_held.delete();
            m_out       = '0;
            m_drop      = 1'b0;
            m_in_frame  = 1'b0;
            m_len       = 0;
            m_frame_len = 0;
            m_idle      = '0;
            m_fd        = 1'b0;
            m_to        = 1'b0;
            m_uf        = 1'b0;
            ready       = 1'b0;
            return;
        end
        ready    = m_drop || (m_held.size() == 0) || (re && !fl);
        hs       = v && ready;
        idle_run = m_in_frame && !m_drop && !v && (timeout_cfg != '0);
        m_uf     = re && (m_held.size() == 0) && !fl;
        m_fd     = 1'b0;
        m_to     = 1'b0;
        if (hs) begin
            m_idle = '0;
        end else if (idle_run) begin
            if (m_idle + TW'(1) == timeout_cfg) begin
                m_to   = 1'b1;
                m_idle = '0;
            end else begin
                m_idle = m_idle + TW'(1);
            end
        end
        if (fl) begin
            m_held.delete();
            m_len = 0;
            if (!m_drop) m_drop = m_in_frame;
            m_in_frame = 1'b0;
        end else if (m_drop) begin
            if (hs && l) m_drop = 1'b0;
        end else begin
            if (re && m_held.size() != 0) void'(m_held.pop_front());
            if (hs) begin
                w = '{data: d, last: l, user: u};
                m_held.push_back(w);
                m_out = w;
                if (l) begin
                    m_frame_len = sat_inc(m_len);
                    m_len       = 0;
                    m_in_frame  = 1'b0;
                    m_fd        = 1'b1;
                end else begin
                    m_len      = sat_inc(m_len);
                    m_in_frame = 1'b1;
                end
            end
        end
        if (m_to) begin
            m_in_frame = 1'b0;
            m_len      = 0;
        end
    endtask

    // One clock: drive at negedge, check tready, clock, check registered outputs.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l,
                        input logic [UW-1:0] u, input logic re, input logic fl,
                        output logic rdy_dut);
        bit rdy;
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        rd_en         = re;
        flush         = fl;
        #1;
        rdy_dut = s_axis_tready;
        model_step(v, d, l, u, re, fl, rst_n, rdy);
        chk("tready", 32'(s_axis_tready), 32'(rdy));
        @(posedge clk);
        @(negedge clk);
        chk("rd_valid",   32'(rd_valid),   32'(m_held.size() != 0));
        chk("rd_data",    32'(rd_data),    32'(m_out.data));
        chk("rd_last",    32'(rd_last),    32'(m_out.last));
        chk("rd_user",    32'(rd_user),    32'(m_out.user));
        chk("frame_len",  32'(frame_len),  32'(m_frame_len));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("timeout",    32'(timeout),    32'(m_to));
        chk("underflow",  32'(underflow),  32'(m_uf));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        logic rdy;
        int   rnd;

        vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 16'd0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 16'd0};
        vecs[2] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 16'd0};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 16'd0};
        vecs[4] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 16'd3};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 16'd3};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 16'd3};

        rst_n         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
        rd_en         = 1'b0;
        flush         = 1'b0;
        timeout_cfg   = '0;
        @(negedge clk);

        // Reset state.
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
        chk("reset tready", 32'(rdy), 32'(0));
        chk("reset rd_valid", 32'(rd_valid), 32'(0));
        chk("reset frame_len", 32'(frame_len), 32'(0));

        // Underflow at reset exit.
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
        chk("uf pulse", 32'(underflow), 32'(1));
        chk("uf rd_data", 32'(rd_data), 32'(0));
        chk("uf rd_valid", 32'(rd_valid), 32'(0));
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
        chk("uf one cycle", 32'(underflow), 32'(0));

        // Basic 3-word frame from the vector table.
        for (int i = 0; i < 7; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].l, 1'b0, vecs[i].re, 1'b0, rdy);
            chk("vec rd_valid",   32'(rd_valid),   32'(vecs[i].ev));
            chk("vec rd_data",    32'(rd_data),    32'(vecs[i].ed));
            chk("vec rd_last",    32'(rd_last),    32'(vecs[i].el));
            chk("vec frame_done", 32'(frame_done), 32'(vecs[i].efd));
            chk("vec frame_len",  32'(frame_len),  32'(vecs[i].elen));
        end

        // Back-to-back: 8 words, rd_en and tvalid held high.
        for (int k = 0; k < 8; k++) begin
            step(1'b1, DW'(8'hA0 + k), (k == 7), 1'b0, 1'b1, 1'b0, rdy);
            chk("b2b tready", 32'(rdy), 32'(1));
            chk("b2b rd_valid", 32'(rd_valid), 32'(1));
            chk("b2b rd_data", 32'(rd_data), 32'(8'hA0 + k));
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
        chk("b2b drained", 32'(rd_valid), 32'(0));
        chk("b2b frame_len", 32'(frame_len), 32'(8));

        // Timeout after 4 idle cycles, then a clean 2-word frame.
        timeout_cfg = TW'(4);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
            chk("tmo pulse", 32'(timeout), 32'(k == 4));
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
        chk("tmo one cycle", 32'(timeout), 32'(0));
        step(1'b1, 8'h61, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
        step(1'b1, 8'h62, 1'b1, 1'b0, 1'b0, 1'b0, rdy);
        chk("tmo next len", 32'(frame_len), 32'(2));
        chk("tmo next done", 32'(frame_done), 32'(1));
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
        timeout_cfg = '0;

        // Flush after word 2 of 5, together with rd_en.
        step(1'b1, 8'h71, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
        step(1'b1, 8'h72, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, rdy);
        chk("flush no uf", 32'(underflow), 32'(0));
        chk("flush rd_valid", 32'(rd_valid), 32'(0));
        for (int k = 3; k <= 5; k++) begin
            step(1'b1, DW'(8'h70 + k), (k == 5), 1'b0, 1'b0, 1'b0, rdy);
            chk("drop tready", 32'(rdy), 32'(1));
            chk("drop no done", 32'(frame_done), 32'(0));
            chk("drop rd_valid", 32'(rd_valid), 32'(0));
            chk("drop frame_len", 32'(frame_len), 32'(2));
        end
        step(1'b1, 8'h81, 1'b1, 1'b1, 1'b0, 1'b0, rdy);
        chk("post flush data", 32'(rd_data), 32'(8'h81));
        chk("post flush user", 32'(rd_user), 32'(1));
        chk("post flush len", 32'(frame_len), 32'(1));
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, rdy);

        // Reset for one cycle while FULL mid-frame.
        step(1'b1, 8'h91, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
        rst_n = 1'b0;
        step(1'b1, 8'h92, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
        chk("rst mid tready", 32'(rdy), 32'(0));
        chk("rst mid rd_valid", 32'(rd_valid), 32'(0));
        chk("rst mid rd_data", 32'(rd_data), 32'(0));
        chk("rst mid frame_len", 32'(frame_len), 32'(0));
        rst_n = 1'b1;
        step(1'b1, 8'h92, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
        step(1'b1, 8'h93, 1'b1, 1'b0, 1'b0, 1'b0, rdy);
        chk("rst next len", 32'(frame_len), 32'(2));
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, rdy);

        // Randomized traffic against the model.
        for (int blk = 0; blk < 6; blk++) begin
            rnd = int'($urandom_range(0, 3));
            timeout_cfg = (rnd == 0) ? TW'(0) : TW'(rnd + 1);
            for (int k = 0; k < 500; k++) begin
                rst_n = ($urandom_range(0, 299) != 0);
                step(($urandom_range(0, 9) < 6), DW'($urandom), ($urandom_range(0, 3) == 0),
                     UW'($urandom), ($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0), rdy);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
